// File: rtl/imem_line_responder_pkg.sv
// imem_line_responder_pkg: shared constants, types and helpers for the fetch line responder
package imem_line_responder_pkg;
  localparam int LINE_BYTES = 32;
  localparam int BURST_BEATS = 4;
  localparam int BEAT_WIDTH = 64;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int BEAT_BITS = $clog2(BURST_BEATS);
  typedef enum logic [1:0] {IDLE, REQ, FILL} imem_resp_state_t;
  typedef logic [255:0] line_t;
  function automatic logic [31:0] word_of(input line_t line, input logic [2:0] idx);
    return line[{idx, 5'b0} +: 32];
  endfunction
endpackage

// File: rtl/imem_line_responder_if.sv
// imem_line_responder_if: fetch-side word port plus backing-memory burst port
interface imem_line_responder_if;
  import imem_line_responder_pkg::*;
  logic [31:0] imem_addr;
  logic [3:0] imem_rmask;
  logic [31:0] imem_rdata;
  logic imem_resp;
  logic [31:0] bmem_addr;
  logic bmem_read;
  logic bmem_ready;
  logic [BEAT_WIDTH-1:0] bmem_rdata;
  logic bmem_rvalid;
  modport master (
    output imem_addr, imem_rmask, bmem_ready, bmem_rdata, bmem_rvalid,
    input imem_rdata, imem_resp, bmem_addr, bmem_read
  );
  modport slave (
    input imem_addr, imem_rmask, bmem_ready, bmem_rdata, bmem_rvalid,
    output imem_rdata, imem_resp, bmem_addr, bmem_read
  );
endinterface

// File: rtl/imem_line_store.sv
// imem_line_store: single 32-byte line buffer with beat write port and word read port
module imem_line_store
  import imem_line_responder_pkg::*;
#(
  parameter logic [26:0] RESET_TAG = 27'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [BEAT_BITS-1:0]  wr_beat,
  input  logic [BEAT_WIDTH-1:0] wr_data,
  input  logic                  set_valid,
  input  logic [26:0]           set_tag,
  input  logic                  clr_valid,
  input  logic [2:0]            rd_idx,
  output logic [31:0]           rd_word,
  output logic [26:0]           tag,
  output logic                  valid
);
  line_t line;
  always_ff @(posedge clk)
    if (wr_en) line[{wr_beat, 6'b0} +: BEAT_WIDTH] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag <= RESET_TAG;
    end else if (set_valid) begin
      valid <= 1'b1;
      tag <= set_tag;
    end else if (clr_valid) begin
      valid <= 1'b0;
    end
  end
  assign rd_word = word_of(line, rd_idx);
endmodule

// File: rtl/imem_line_responder.sv
// imem_line_responder: answers fetch word requests from one line buffer, refilling by 4-beat bursts on miss
module imem_line_responder
  import imem_line_responder_pkg::*;
#(
  parameter logic [26:0] RESET_TAG = 27'h0
) (
  input logic clk,
  input logic rst,
  imem_line_responder_if.slave bus
);
  imem_resp_state_t state, state_d;
  logic [29:0] req_addr, req_addr_d;
  logic [BEAT_BITS-1:0] beat_cnt, beat_cnt_d;
  logic resp, resp_d;
  logic [31:0] rdata, rdata_d;
  logic req, hit, wr_en, set_valid, clr_valid, line_valid;
  logic [26:0] line_tag;
  logic [31:0] line_word, fill_word;
  logic [2:0] rd_idx;
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.imem_addr[1:0];
  assign req = bus.imem_rmask != 4'h0;
  assign hit = line_valid && line_tag == bus.imem_addr[31:5];
  assign wr_en = state == FILL && bus.bmem_rvalid;
  assign rd_idx = state == IDLE ? bus.imem_addr[4:2] : req_addr[2:0];
  // The requested word may arrive in the final beat, which is not in the store yet.
  assign fill_word = &req_addr[2:1] ? (req_addr[0] ? bus.bmem_rdata[63:32] : bus.bmem_rdata[31:0]) : line_word;
  imem_line_store #(.RESET_TAG(RESET_TAG)) u_store (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_beat   (beat_cnt),
    .wr_data   (bus.bmem_rdata),
    .set_valid (set_valid),
    .set_tag   (req_addr[29:3]),
    .clr_valid (clr_valid),
    .rd_idx    (rd_idx),
    .rd_word   (line_word),
    .tag       (line_tag),
    .valid     (line_valid)
  );
  always_comb begin
    state_d = state;
    req_addr_d = req_addr;
    beat_cnt_d = beat_cnt;
    resp_d = 1'b0;
    rdata_d = rdata;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    case (state)
      IDLE: if (req && hit) begin
        resp_d = 1'b1;
        rdata_d = line_word;
      end else if (req) begin
        req_addr_d = bus.imem_addr[31:2];
        clr_valid = 1'b1;
        state_d = REQ;
      end
      REQ: if (bus.bmem_ready) begin
        beat_cnt_d = '0;
        state_d = FILL;
      end
      FILL: if (bus.bmem_rvalid) begin
        beat_cnt_d = beat_cnt + 1'b1;
        if (&beat_cnt) begin
          set_valid = 1'b1;
          resp_d = 1'b1;
          rdata_d = fill_word;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_addr <= '0;
      beat_cnt <= '0;
      resp <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_d;
      req_addr <= req_addr_d;
      beat_cnt <= beat_cnt_d;
      resp <= resp_d;
      rdata <= rdata_d;
    end
  end
  assign bus.imem_resp = resp;
  assign bus.imem_rdata = rdata;
  assign bus.bmem_read = state == REQ;
  assign bus.bmem_addr = {req_addr[29:3], {OFFSET_BITS{1'b0}}};
endmodule

// File: doc/imem_line_responder.md
Name: imem_line_responder

Overview:
Responder for the instruction-fetch memory port. It receives 32-bit word fetch requests (imem_addr/imem_rmask) from the fetch stage and answers them with imem_rdata/imem_resp. A single 32-byte line buffer serves hits. On a miss, the block issues a 4-beat, 64-bit burst read to backing memory, fills the line, then responds. It sits between the fetch stage and the burst memory model/arbiter.

Parameters:
BEAT_WIDTH, 64, bits per backing-memory beat; fixed at 64.
BURST_BEATS, 4, beats per line; fixed at 4, so line = 256 bits = 8 words.
RESET_TAG, 27'h0, tag register reset value; line_valid gates its use.

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
imem_addr  in  32  fetch byte address; bits [1:0] ignored
imem_rmask  in  4  nonzero = request valid this cycle; any nonzero mask returns the full word
imem_rdata  out  32  fetched word; meaningful only when imem_resp=1
imem_resp  out  1  one-cycle response pulse, exactly one per accepted request
bmem_addr  out  32  line-aligned burst address {tag,5'b0}
bmem_read  out  1  burst read request, held until accepted
bmem_ready  in  1  memory accepts bmem_read in a cycle where both are high
bmem_rdata  in  64  burst beat data, lowest address first
bmem_rvalid  in  1  beat valid

Behaviour:
- Reset values:
  - state=IDLE, line_valid=0, beat_cnt=0, tag=RESET_TAG.
  - imem_resp=0, imem_rdata=0, bmem_read=0, bmem_addr=0.
- Request acceptance:
  - A request is accepted only in IDLE with imem_rmask!=0.
  - Requests in REQ or FILL are ignored; the fetch stage holds the request until resp.
- Address split:
  - tag = addr[31:5]; word index = addr[4:2].
  - Beat k holds words 2k (low 32 bits) and 2k+1 (high 32 bits).
- Hit (line_valid && tag match):
  - Next cycle: imem_resp=1 and imem_rdata = selected word.
  - Latency 1; state stays IDLE.
- Miss:
  - Latch the request address, clear line_valid, enter REQ.
  - REQ: bmem_read=1 and bmem_addr={req_tag,5'b0}. On bmem_ready=1, drop bmem_read next cycle, enter FILL with beat_cnt=0.
  - FILL: each bmem_rvalid writes beat beat_cnt into the line and increments beat_cnt (2-bit wrap).
  - On the 4th beat, set tag=req_tag and line_valid=1, return to IDLE.
  - The following cycle: imem_resp=1 with the requested word.
  - Miss latency = 1 + REQ wait + memory latency + 4 beats + 1.
- Back-to-back:
  - The response cycle is an IDLE cycle, so a new request presented in it is accepted.
  - Sustained hit throughput: 1 word/cycle.
- imem_resp is registered; it is never high for two consecutive cycles for one request.
- bmem_rvalid outside FILL is ignored (drops stale beats after reset).
- Reset mid-REQ or mid-FILL:
  - Abort; bmem_read=0 and line_valid=0 next cycle.
  - No imem_resp is ever issued for the aborted request.
- rst has priority over every other event in the same cycle.

Decomposition:
- Shared package (rv32i_types or a memory-port package):
  - constants LINE_BYTES=32, BURST_BEATS=4, BEAT_WIDTH=64;
  - typedef imem_resp_state_t enum {IDLE, REQ, FILL};
  - typedef line_t logic [255:0].
- One natural sub-module: imem_line_store.
  - Holds the 4×64 line data, tag and valid.
  - Provides a beat-write port and a combinational word-select read port.
  - The FSM and handshake live in the top block.

Test Plan:
- Reset, then rmask=4'hf at 0x1eceb000; memory latency 3, beats 0x..0001_0000_0000..0003 -> one bmem_read to 0x1eceb000, imem_resp after the 4th beat +1 cycle, imem_rdata=word0; exactly one resp.
- After the fill, requests at 0x1eceb004..0x1eceb01c on consecutive cycles -> resp every cycle, correct words 1..7, no bmem_read.
- Request 0x1eceb020 (next line) -> miss, bmem_addr=0x1eceb020; then 0x1eceb000 -> miss again (single line buffer).
- Assert rst after the 2nd beat of a fill, keep bmem_rvalid pulsing -> no resp, bmem_read=0, line_valid=0; a subsequent request to the same address misses.
- bmem_ready held low 5 cycles -> bmem_read and bmem_addr stable throughout; fill starts only after ready.
- rmask=0 with arbitrary addr, and requests presented during FILL -> no acceptance, no extra resp, no extra bursts.
